// File: rtl/seg7_scan_encoder.sv
// seg7_scan_encoder: rebuilds a 4-digit value from a scanned, active-low
// seven-segment bus and holds each complete frame until the consumer acks it.
// Ports: Clk, Reset (sync, active-high); Hex[0:6]=segments a..g, DigitSel
// (one-hot), Strobe, Ack in; Value, Blank, Valid, Err, DropCnt out.
// Macro SEG7_DROP_CNT_EN: counts strobes dropped while a frame is held.
module seg7_scan_encoder (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [0:6]  Hex,
    input  logic [3:0]  DigitSel,
    input  logic        Strobe,
    input  logic        Ack,
    output logic [15:0] Value,
    output logic [3:0]  Blank,
    output logic        Valid,
    output logic        Err,
    output logic [7:0]  DropCnt
);

    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_HOLD    = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [15:0] slot_q, slot_d;
    logic [3:0]  sblank_q, sblank_d;
    logic [3:0]  seen_q, seen_d;
    logic        ferr_q, ferr_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  blank_q, blank_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [3:0]  dec_nib;
    logic        dec_blank;
    logic        dec_bad;
    logic        sel_ok;

    // Literal MSB lines up with Hex[0] (segment a).
    always_comb begin
        dec_nib   = 4'h0;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (Hex)
            7'b0000001: dec_nib = 4'h0;
            7'b1001111: dec_nib = 4'h1;
            7'b0010010: dec_nib = 4'h2;
            7'b0000110: dec_nib = 4'h3;
            7'b1001100: dec_nib = 4'h4;
            7'b0100100: dec_nib = 4'h5;
            7'b0100000: dec_nib = 4'h6;
            7'b0001111: dec_nib = 4'h7;
            7'b0000000: dec_nib = 4'h8;
            7'b0000100: dec_nib = 4'h9;
            7'b0001000: dec_nib = 4'hA;
            7'b1100000: dec_nib = 4'hB;
            7'b0110001: dec_nib = 4'hC;
            7'b1000010: dec_nib = 4'hD;
            7'b0110000: dec_nib = 4'hE;
            7'b0111000: dec_nib = 4'hF;
            7'b1111111: dec_blank = 1'b1;
            default:    dec_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (DigitSel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_ok = 1'b1;
            default:                            sel_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        sblank_d = sblank_q;
        seen_d   = seen_q;
        ferr_d   = ferr_q;
        value_d  = value_q;
        blank_d  = blank_q;
        valid_d  = valid_q;
        err_d    = err_q;
        case (state_q)
            S_COLLECT: begin
                if (Strobe) begin
                    if (sel_ok) begin
                        for (int k = 0; k < 4; k++) begin
                            if (DigitSel[k]) begin
                                slot_d[4*k +: 4] = dec_nib;
                                sblank_d[k]      = dec_blank;
                            end
                        end
                        seen_d = seen_q | DigitSel;
                        ferr_d = ferr_q | dec_bad;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                // Publish in the same edge the last digit lands.
                if (seen_d == 4'hF) begin
                    value_d = slot_d;
                    blank_d = sblank_d;
                    err_d   = ferr_d;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            default: begin
                if (Ack) begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    seen_d  = 4'h0;
                    ferr_d  = 1'b0;
                    state_d = S_COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_COLLECT;
            slot_q   <= '0;
            sblank_q <= '0;
            seen_q   <= '0;
            ferr_q   <= 1'b0;
            value_q  <= '0;
            blank_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            sblank_q <= sblank_d;
            seen_q   <= seen_d;
            ferr_q   <= ferr_d;
            value_q  <= value_d;
            blank_q  <= blank_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

`ifdef SEG7_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            drop_q <= '0;
        end else if (state_q == S_HOLD && Strobe && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign DropCnt = drop_q;
`else
    assign DropCnt = 8'h00;
`endif

    assign Value = value_q;
    assign Blank = blank_q;
    assign Valid = valid_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_seg7_scan_encoder.sv
// tb_seg7_scan_encoder: scoreboard bench for seg7_scan_encoder.
// Frames predicted by a digit-array model are queued and checked on Valid.
module tb_seg7_scan_encoder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [0:6]  Hex;
    logic [3:0]  DigitSel;
    logic        Strobe;
    logic        Ack;
    logic [15:0] Value;
    logic [3:0]  Blank;
    logic        Valid;
    logic        Err;
    logic [7:0]  DropCnt;

    seg7_scan_encoder dut (
        .Clk(Clk), .Reset(Reset), .Hex(Hex), .DigitSel(DigitSel),
        .Strobe(Strobe), .Ack(Ack), .Value(Value), .Blank(Blank),
        .Valid(Valid), .Err(Err), .DropCnt(DropCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  b;
        logic        e;
    } exp_t;

    exp_t exp_q[$];

    logic [0:6] pat [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [0:6] BLANKP = 7'b1111111;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: per-digit arrays and a held-frame flag.
    int  m_dig [4];
    bit  m_blk [4];
    bit  m_seen [4];
    bit  m_ferr;
    bit  m_hold;
    bit  m_valid;
    bit  m_err;
    int  m_value;
    int  m_blank;
    int  m_drop;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_dig[k] = 0;
            m_blk[k] = 0;
            m_seen[k] = 0;
        end
        m_ferr = 0; m_hold = 0; m_valid = 0; m_err = 0;
        m_value = 0; m_blank = 0; m_drop = 0;
    endtask

    task automatic model(bit s, logic [3:0] ds, logic [0:6] hx, bit a, bit r);
        int idx;
        bit all;
        exp_t x;
        if (r) begin
            model_reset();
            return;
        end
        if (m_hold) begin
`ifdef SEG7_DROP_CNT_EN
            if (s && m_drop < 255) m_drop++;
`endif
            if (a) begin
                m_hold = 0; m_valid = 0; m_err = 0; m_ferr = 0;
                for (int k = 0; k < 4; k++) m_seen[k] = 0;
            end
            return;
        end
        if (s) begin
            if ($countones(ds) == 1) begin
                idx = -1;
                for (int i = 0; i < 16; i++) if (pat[i] == hx) idx = i;
                for (int k = 0; k < 4; k++) begin
                    if (ds[k]) begin
                        m_dig[k] = (idx < 0) ? 0 : idx;
                        m_blk[k] = (hx == BLANKP);
                        m_seen[k] = 1;
                        if (idx < 0 && hx != BLANKP) m_ferr = 1;
                    end
                end
            end else begin
                m_ferr = 1;
            end
        end
        all = 1;
        for (int k = 0; k < 4; k++) if (!m_seen[k]) all = 0;
        if (all) begin
            m_value = 0;
            m_blank = 0;
            for (int k = 0; k < 4; k++) begin
                m_value += m_dig[k] * (1 << (4 * k));
                if (m_blk[k]) m_blank += (1 << k);
            end
            m_hold = 1; m_valid = 1; m_err = m_ferr;
            x.v = m_value[15:0];
            x.b = m_blank[3:0];
            x.e = m_ferr;
            exp_q.push_back(x);
        end
    endtask

    task automatic step(bit s, logic [3:0] ds, logic [0:6] hx, bit a, bit r);
        Strobe = s; DigitSel = ds; Hex = hx; Ack = a; Reset = r;
        @(posedge Clk);
        model(s, ds, hx, a, r);
        #1;
    endtask

    task automatic dig(int k, logic [0:6] hx);
        step(1, 4'b0001 << k, hx, 0, 0);
    endtask

    task automatic idle();
        step(0, 4'h0, BLANKP, 0, 0);
    endtask

    task automatic ack();
        step(0, 4'h0, BLANKP, 1, 0);
    endtask

    task automatic rst();
        step(0, 4'h0, BLANKP, 0, 1);
    endtask

    // Monitor: pop a frame on each Valid rise; track held outputs each cycle.
    logic prev_valid = 1'b0;
    always @(negedge Clk) begin
        exp_t x;
        if (Reset !== 1'bx && $time > 20) begin
            if (Valid === 1'b1 && prev_valid !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    check("frame_value", Value, x.v);
                    check("frame_blank", Blank, x.b);
                    check("frame_err", Err, x.e);
                end
            end
            check("valid", Valid, m_valid);
            check("value_hold", Value, m_value[15:0]);
            check("blank_hold", Blank, m_blank[3:0]);
            check("err_gate", Err, m_valid ? m_err : 1'b0);
            check("dropcnt", DropCnt, m_drop[7:0]);
        end
        prev_valid = Valid;
    end

    initial begin
        int exp_drop;
        model_reset();
        Strobe = 0; DigitSel = 0; Hex = BLANKP; Ack = 0; Reset = 1;
        rst();
        rst();
        check("rst_value", Value, 16'h0);
        check("rst_valid", Valid, 1'b0);
        check("rst_drop", DropCnt, 8'h0);

        // Basic legal frame.
        dig(0, pat[3]); dig(1, pat[10]); dig(2, pat[12]);
        check("pre_valid", Valid, 1'b0);
        dig(3, pat[1]);
        check("basic_valid", Valid, 1'b1);
        check("basic_value", Value, 16'h1CA3);
        check("basic_err", Err, 1'b0);
        ack();

        // Blank and illegal digits.
        dig(0, pat[5]); dig(1, 7'b1111110); dig(2, BLANKP); dig(3, pat[7]);
        check("blank_flag", Blank, 4'b0100);
        check("illegal_nib", Value[7:4], 4'h0);
        check("illegal_err", Err, 1'b1);
        ack();
        check("ack_err_clr", Err, 1'b0);

        // Bad DigitSel poisons the frame; next clean frame is clean.
        step(1, 4'b0011, pat[2], 0, 0);
        for (int k = 0; k < 4; k++) dig(k, pat[k + 4]);
        check("badsel_err", Err, 1'b1);
        ack();
        for (int k = 0; k < 4; k++) dig(k, pat[k + 8]);
        check("clean_err", Err, 1'b0);
        ack();

        // Drops in HOLD.
        rst();
        for (int k = 0; k < 4; k++) dig(k, pat[15 - k]);
        for (int k = 0; k < 3; k++) dig(k, pat[0]);
        check("hold_value", Value, 16'hCDEF);
        step(1, 4'b0001, pat[0], 1, 0);
`ifdef SEG7_DROP_CNT_EN
        exp_drop = 4;
`else
        exp_drop = 0;
`endif
        check("drop_count", DropCnt, exp_drop[7:0]);
        dig(1, pat[1]); dig(2, pat[2]); dig(3, pat[3]);
        check("fresh_needed", Valid, 1'b0);
        dig(0, pat[0]);
        check("fresh_frame", Value, 16'h3210);
        ack();

        // Overwrite before completion.
        dig(0, pat[5]); dig(1, pat[1]); dig(0, pat[9]);
        dig(2, pat[2]); dig(3, pat[3]);
        check("last_wins", Value[3:0], 4'h9);
        ack();

        // Reset mid-frame and in HOLD.
        dig(0, pat[1]); dig(1, pat[2]);
        rst();
        check("rst_mid_value", Value, 16'h0);
        dig(2, pat[4]); dig(3, pat[5]);
        check("rst_mid_novalid", Valid, 1'b0);
        dig(0, pat[6]); dig(1, pat[7]);
        check("rst_mid_frame", Value, 16'h5476);
        step(1, 4'b0010, pat[0], 1, 1);
        check("rst_hold_valid", Valid, 1'b0);
        check("rst_hold_value", Value, 16'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            bit s, a, r;
            logic [3:0] ds;
            logic [0:6] hx;
            int c;
            s = ($urandom_range(0, 2) != 0);
            a = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 150) == 0);
            if ($urandom_range(0, 9) == 0) ds = 4'($urandom);
            else ds = 4'b0001 << $urandom_range(0, 3);
            c = $urandom_range(0, 19);
            if (c < 16) hx = pat[c];
            else if (c < 18) hx = BLANKP;
            else hx = 7'($urandom);
            step(s, ds, hx, a, r);
        end

        idle();
        idle();
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
